// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register file: default widths, register
// index type, register-file state encoding and the hardwired-zero index.
package cpu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int RA_W_DEF = $clog2(NREG_DEF);

  typedef logic [RA_W_DEF-1:0] reg_idx_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set on issue and
// cleared on retirement; a same-cycle issue beats a retire to the same register.
module regfile_sb_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  localparam int RA_W = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            set_en_i,
  input  logic [RA_W-1:0] set_idx_i,
  input  logic            clr_en_i,
  input  logic [RA_W-1:0] clr_idx_i,
  input  logic [RA_W-1:0] rd_a_idx_i,
  input  logic [RA_W-1:0] rd_b_idx_i,
  output logic            busy_a_o,
  output logic            busy_b_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_d[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit    = set_en_i & (set_idx_i == RA_W'(gi));
        assign clr_hit    = clr_en_i & (clr_idx_i == RA_W'(gi));
        // The new producer wins over the retiring one.
        assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_a_o = busy_q[rd_a_idx_i];
  assign busy_b_o = busy_q[rd_b_idx_i];

endmodule

// File: rtl/regfile_sb.sv
// Register file with hardwired x0, two combinational read ports, optional
// write-to-read bypass, RAW scoreboard and a one-entry-per-cycle clear engine.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int BYPASS = 1,
  localparam int RA_W  = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CE,
  input  logic            WE,
  input  logic [RA_W-1:0] AW,
  input  logic [XLEN-1:0] D,
  input  logic [RA_W-1:0] AR,
  input  logic [RA_W-1:0] BR,
  input  logic            ISSUE,
  input  logic [RA_W-1:0] ISSUE_RD,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic            A_BUSY,
  output logic            B_BUSY,
  output logic            READY
);

  localparam logic [RA_W-1:0] IDX_ZERO  = RA_W'(REG_ZERO);
  localparam logic [RA_W-1:0] IDX_FIRST = RA_W'(1);
  localparam logic [RA_W-1:0] IDX_LAST  = RA_W'(NREG - 1);

  rf_state_e       state_q, state_d;
  logic [RA_W-1:0] clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;

  logic [XLEN-1:0] mem_q [NREG];

  logic            run;
  logic            wr_hit;
  logic            issue_ok;
  logic            mem_we;
  logic [RA_W-1:0] mem_wa;
  logic [XLEN-1:0] mem_wd;

  assign run      = (state_q == ST_RUN);
  assign wr_hit   = run & CE & WE & (AW != IDX_ZERO);
  assign issue_ok = run & CE & ISSUE & (ISSUE_RD != IDX_ZERO);

  // The clear engine and architectural writes share the single write port,
  // so the array needs no reset and can map onto RAM primitives.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_wa    = AW;
    mem_wd    = D;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_idx_q;
        mem_wd = '0;
        if (clr_idx_q == IDX_LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + IDX_FIRST;
        end
      end
      ST_RUN: begin
        mem_we = wr_hit;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
    if (RST) begin
      state_d   = ST_CLEAR;
      clr_idx_d = IDX_FIRST;
      ready_d   = 1'b0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    ready_q   <= ready_d;
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  logic [XLEN-1:0] rd_a;
  logic [XLEN-1:0] rd_b;
  logic            hit_a;
  logic            hit_b;
  logic            busy_a;
  logic            busy_b;

  assign rd_a  = (AR == IDX_ZERO) ? '0 : mem_q[AR];
  assign rd_b  = (BR == IDX_ZERO) ? '0 : mem_q[BR];
  // wr_hit already excludes x0, so a hit implies a non-zero read address.
  assign hit_a = wr_hit & (AW == AR);
  assign hit_b = wr_hit & (AW == BR);

  regfile_sb_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .CLK        (CLK),
    .RST        (RST),
    .set_en_i   (issue_ok),
    .set_idx_i  (ISSUE_RD),
    .clr_en_i   (wr_hit),
    .clr_idx_i  (AW),
    .rd_a_idx_i (AR),
    .rd_b_idx_i (BR),
    .busy_a_o   (busy_a),
    .busy_b_o   (busy_b)
  );

  generate
    if (BYPASS != 0) begin : g_bypass
      assign A      = hit_a ? D : rd_a;
      assign B      = hit_b ? D : rd_b;
      assign A_BUSY = ~run | (busy_a & ~hit_a);
      assign B_BUSY = ~run | (busy_b & ~hit_b);
    end else begin : g_no_bypass
      // Without bypass the reader sees stale data, so the hazard must stay up.
      assign A      = rd_a;
      assign B      = rd_b;
      assign A_BUSY = ~run | busy_a;
      assign B_BUSY = ~run | busy_b;
    end
  endgenerate

  assign READY = ready_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance
// driven by the same stimulus, with hand-computed expectations.
module tb_regfile_sb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE;
  logic        WE;
  logic [4:0]  AW;
  logic [31:0] D;
  logic [4:0]  AR;
  logic [4:0]  BR;
  logic        ISSUE;
  logic [4:0]  ISSUE_RD;

  logic [31:0] a1, b1, a0, b0;
  logic        a_busy1, b_busy1, a_busy0, b_busy0;
  logic        ready1, ready0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) u_dut (
    .CLK(CLK), .RST(RST), .CE(CE), .WE(WE), .AW(AW), .D(D),
    .AR(AR), .BR(BR), .ISSUE(ISSUE), .ISSUE_RD(ISSUE_RD),
    .A(a1), .B(b1), .A_BUSY(a_busy1), .B_BUSY(b_busy1), .READY(ready1)
  );

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) u_dut_nb (
    .CLK(CLK), .RST(RST), .CE(CE), .WE(WE), .AW(AW), .D(D),
    .AR(AR), .BR(BR), .ISSUE(ISSUE), .ISSUE_RD(ISSUE_RD),
    .A(a0), .B(b0), .A_BUSY(a_busy0), .B_BUSY(b_busy0), .READY(ready0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Expects READY low for 31 cycles after the reset edge, then high.
  task automatic check_clear(input string tag);
    for (int i = 0; i < 31; i++) begin
      settle();
      check($sformatf("%s ready_low[%0d]", tag, i), {31'd0, ready1}, 32'd0);
      check($sformatf("%s a_busy[%0d]", tag, i), {31'd0, a_busy1}, 32'd1);
      tick();
    end
    check($sformatf("%s ready_high", tag), {31'd0, ready1}, 32'd1);
    check($sformatf("%s ready_high_nb", tag), {31'd0, ready0}, 32'd1);
  endtask

  task automatic write(input logic [4:0] addr, input logic [31:0] data);
    WE = 1'b1; AW = addr; D = data;
    tick();
    WE = 1'b0;
  endtask

  initial begin
    RST = 1'b1; CE = 1'b1; WE = 1'b0; AW = '0; D = '0;
    AR = '0; BR = '0; ISSUE = 1'b0; ISSUE_RD = '0;

    // Reset and clear sequence
    tick();
    RST = 1'b0;
    check_clear("clr1");

    for (int r = 0; r < 32; r++) begin
      AR = 5'(r); BR = 5'(31 - r);
      settle();
      check($sformatf("zero A[%0d]", r), a1, 32'd0);
      check($sformatf("zero B[%0d]", 31 - r), b1, 32'd0);
    end
    AR = 5'd1;
    settle();
    check("idle a_busy", {31'd0, a_busy1}, 32'd0);

    // Basic write / read, x0 discard
    write(5'd5, 32'hDEADBEEF);
    AR = 5'd5; settle();
    check("rd5 A", a1, 32'hDEADBEEF);
    check("rd5 A nb", a0, 32'hDEADBEEF);
    write(5'd0, 32'h00001234);
    AR = 5'd0; settle();
    check("rd0 A", a1, 32'd0);
    check("rd0 A nb", a0, 32'd0);

    // Bypass vs no bypass
    write(5'd7, 32'h11111111);
    WE = 1'b1; AW = 5'd7; D = 32'hA5A5A5A5; AR = 5'd7; BR = 5'd7;
    settle();
    check("byp A", a1, 32'hA5A5A5A5);
    check("byp B", b1, 32'hA5A5A5A5);
    check("nobyp A", a0, 32'h11111111);
    check("nobyp B", b0, 32'h11111111);
    tick();
    WE = 1'b0; settle();
    check("after byp A nb", a0, 32'hA5A5A5A5);

    // Scoreboard
    ISSUE = 1'b1; ISSUE_RD = 5'd3;
    tick();
    ISSUE = 1'b0; AR = 5'd3; BR = 5'd3; settle();
    check("sb set a_busy", {31'd0, a_busy1}, 32'd1);
    check("sb set b_busy", {31'd0, b_busy1}, 32'd1);
    check("sb set a_busy nb", {31'd0, a_busy0}, 32'd1);
    WE = 1'b1; AW = 5'd3; D = 32'h00000033; settle();
    check("sb retire same-cycle a_busy", {31'd0, a_busy1}, 32'd0);
    check("sb retire same-cycle A", a1, 32'h00000033);
    tick();
    WE = 1'b0; settle();
    check("sb retired a_busy", {31'd0, a_busy1}, 32'd0);
    check("sb retired a_busy nb", {31'd0, a_busy0}, 32'd0);

    ISSUE = 1'b1; ISSUE_RD = 5'd3; WE = 1'b1; AW = 5'd3; D = 32'h00000044;
    tick();
    ISSUE = 1'b0; WE = 1'b0; settle();
    check("sb issue+retire a_busy", {31'd0, a_busy1}, 32'd1);
    check("sb issue+retire A", a1, 32'h00000044);
    write(5'd3, 32'h00000045);
    settle();
    check("sb final retire a_busy", {31'd0, a_busy1}, 32'd0);

    ISSUE = 1'b1; ISSUE_RD = 5'd0;
    tick();
    ISSUE = 1'b0; AR = 5'd0; settle();
    check("sb x0 a_busy", {31'd0, a_busy1}, 32'd0);

    // CE gating
    write(5'd9, 32'h00000099);
    CE = 1'b0; WE = 1'b1; AW = 5'd9; D = 32'h000000FF; ISSUE = 1'b1; ISSUE_RD = 5'd9;
    AR = 5'd9; settle();
    check("ce0 no bypass A", a1, 32'h00000099);
    tick();
    CE = 1'b1; WE = 1'b0; ISSUE = 1'b0; settle();
    check("ce0 mem9 kept", a1, 32'h00000099);
    check("ce0 busy9 clear", {31'd0, a_busy1}, 32'd0);
    ISSUE = 1'b1; ISSUE_RD = 5'd9;
    tick();
    ISSUE = 1'b0; CE = 1'b0; WE = 1'b1; AW = 5'd9; D = 32'h000000AB; settle();
    check("ce0 busy9 not masked", {31'd0, a_busy1}, 32'd1);
    tick();
    CE = 1'b1; WE = 1'b0; settle();
    check("ce0 busy9 kept", {31'd0, a_busy1}, 32'd1);
    check("ce0 mem9 kept2", a1, 32'h00000099);

    // Reset mid-clear; writes and issues during CLEAR must be dropped
    RST = 1'b1;
    tick();
    RST = 1'b0;
    WE = 1'b1; AW = 5'd12; D = 32'h0000CAFE; ISSUE = 1'b1; ISSUE_RD = 5'd12;
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("mid ready_low[%0d]", i), {31'd0, ready1}, 32'd0);
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_clear("clr2");
    WE = 1'b0; ISSUE = 1'b0;
    AR = 5'd12; BR = 5'd9; settle();
    check("clr2 mem12 zero", a1, 32'd0);
    check("clr2 busy12 zero", {31'd0, a_busy1}, 32'd0);
    check("clr2 mem9 zero", b1, 32'd0);
    check("clr2 busy9 zero", {31'd0, b_busy1}, 32'd0);
    AR = 5'd5; settle();
    check("clr2 mem5 zero", a1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
